// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_ctrl : N-digit common-anode 7-segment scan controller with
//                 valid/ready load port and frame-aligned value commits.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000,
  parameter int DEAD_CYCLES  = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                    val_valid_in,
  output logic                    val_ready_out,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  output logic [6:0]              cat_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done_out
);

  localparam int CNT_W = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(COUNT_PERIOD - 1);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] c_DEAD     = CNT_W'(DEAD_CYCLES);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_pending;
  logic                    r_pend_valid;

  logic                    w_slot_end;
  logic                    w_wrap;
  logic                    w_hs;
  logic                    w_lit;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg;
  logic [6:0]              w_cat;
  logic [NUM_DIGITS-1:0]   w_an;

  assign val_ready_out = ~r_pend_valid & ~rst_in;
  assign w_hs          = val_valid_in & val_ready_out;
  assign w_slot_end    = (r_cnt == c_CNT_LAST);
  assign w_wrap        = w_slot_end && (r_idx == c_IDX_LAST);
  assign w_lit         = (r_cnt >= c_DEAD);
  assign w_nib         = r_shadow[{r_idx, 2'b00} +: 4];

  // Active-high segment pattern, a..g on bits 0..6
  always_comb begin
    w_seg = 7'h00;
    case (w_nib)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h00;
    endcase
  end

  always_comb begin
    w_cat = digit_en_in[r_idx] ? ~w_seg : 7'h7F;
    w_an  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) == r_idx) && w_lit && digit_en_in[i]) begin
        w_an[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Commit and accept are exclusive: accept needs the buffer empty
      if (w_wrap && r_pend_valid) begin
        r_shadow     <= r_pending;
        r_pend_valid <= 1'b0;
      end else if (w_hs) begin
        r_pending    <= val_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      an_out         <= '1;
      cat_out        <= 7'h7F;
      frame_done_out <= 1'b0;
    end else begin
      an_out         <= w_an;
      cat_out        <= w_cat;
      frame_done_out <= w_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl : randomized self-checking bench against a time-based model
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int ND     = 4;
  localparam int PERIOD = 8;
  localparam int DEAD   = 2;
  localparam int FRAME  = ND * PERIOD;

  logic            clk_in;
  logic            rst_in;
  logic [15:0]     val_in;
  logic            val_valid_in;
  logic            val_ready_out;
  logic [ND-1:0]   digit_en_in;
  logic [6:0]      cat_out;
  logic [ND-1:0]   an_out;
  logic            frame_done_out;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .COUNT_PERIOD (PERIOD),
    .DEAD_CYCLES  (DEAD)
  ) u_dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .val_in         (val_in),
    .val_valid_in   (val_valid_in),
    .val_ready_out  (val_ready_out),
    .digit_en_in    (digit_en_in),
    .cat_out        (cat_out),
    .an_out         (an_out),
    .frame_done_out (frame_done_out)
  );

  // Active-low cathode pattern per hex digit
  logic [6:0] c_SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_t;
  logic [15:0] m_shadow;
  logic [15:0] m_pend;
  logic        m_pv;
  logic        m_hs;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t      = 0;
    m_shadow = '0;
    m_pv     = 1'b0;
    m_hs     = 1'b0;
  endtask

  // Predict the outputs registered at the coming edge from elapsed time since reset
  task automatic step();
    int         cnt;
    int         idx;
    logic [3:0] e_an;
    logic [6:0] e_cat;
    logic       e_fd;
    if (rst_in) begin
      e_an  = 4'hF;
      e_cat = 7'h7F;
      e_fd  = 1'b0;
      m_hs  = 1'b0;
    end else begin
      cnt   = m_t % PERIOD;
      idx   = (m_t / PERIOD) % ND;
      e_an  = (cnt >= DEAD && digit_en_in[idx]) ? ~(4'b0001 << idx) : 4'hF;
      e_cat = digit_en_in[idx] ? c_SEG[m_shadow[4*idx +: 4]] : 7'h7F;
      e_fd  = (m_t % FRAME) == FRAME - 1;
      m_hs  = val_valid_in && !m_pv;
      if (e_fd && m_pv) begin
        m_shadow = m_pend;
        m_pv     = 1'b0;
      end
      if (m_hs) begin
        m_pend = val_in;
        m_pv   = 1'b1;
      end
      m_t++;
    end
    @(posedge clk_in);
    #1;
    chk("an", 32'(an_out), 32'(e_an));
    chk("cat", 32'(cat_out), 32'(e_cat));
    chk("frame_done", 32'(frame_done_out), 32'(e_fd));
    chk("ready", 32'(val_ready_out), rst_in ? 32'd0 : 32'(!m_pv));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic offer(input logic [15:0] v);
    int n;
    n            = 0;
    val_in       = v;
    val_valid_in = 1'b1;
    do begin
      step();
      n++;
    end while (!m_hs && n < 200);
    if (!m_hs) chk("offer_timeout", 32'd0, 32'd1);
    val_valid_in = 1'b0;
  endtask

  task automatic run_until(input int phase);
    int n;
    n = 0;
    while ((m_t % FRAME) != phase && n < 200) begin
      step();
      n++;
    end
    if ((m_t % FRAME) != phase) chk("phase_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_in       = 1'b1;
    val_in       = '0;
    val_valid_in = 1'b0;
    digit_en_in  = 4'hF;
    model_reset();

    // Reset hold
    run(3);
    chk("rst_an", 32'(an_out), 32'hF);
    chk("rst_cat", 32'(cat_out), 32'h7F);
    rst_in = 1'b0;
    #1;
    chk("ready_after_rst", 32'(val_ready_out), 32'd1);

    // Basic load, commit at the first wrap, then a full frame of display
    step();
    offer(16'h1234);
    run(2 * FRAME);

    // Pending full: second value waits for the wrap
    offer(16'hAAAA);
    run(5);
    chk("ready_while_pending", 32'(val_ready_out), 32'd0);
    offer(16'h5555);
    run(2 * FRAME);

    // Per-digit blanking
    digit_en_in = 4'b1011;
    offer(16'h8888);
    run(2 * FRAME);
    digit_en_in = 4'hF;

    // Asynchronous reset mid-slot of digit 2
    run_until(2 * PERIOD + 3);
    #2;
    rst_in = 1'b1;
    #1;
    chk("mid_rst_an", 32'(an_out), 32'hF);
    chk("mid_rst_cat", 32'(cat_out), 32'h7F);
    chk("mid_rst_ready", 32'(val_ready_out), 32'd0);
    model_reset();
    step();
    rst_in = 1'b0;
    run(FRAME + 4);

    // Offer exactly on the wrap cycle with pending empty
    run_until(FRAME - 1);
    val_in       = 16'hC3E7;
    val_valid_in = 1'b1;
    step();
    chk("wrap_accept", 32'(m_hs), 32'd1);
    val_valid_in = 1'b0;
    run(2 * FRAME + 2);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      val_valid_in = ($urandom_range(0, 3) == 0);
      val_in       = 16'($urandom);
      if ($urandom_range(0, 49) == 0) digit_en_in = 4'($urandom);
      step();
    end
    val_valid_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
